mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store request adapter placed directly upstream of the byte-masked, word-organised RAM model.
- Accepts one data access per valid/ready handshake: byte, half or word, read or write.
- Checks alignment, range and size; converts a legal request into a word-aligned RAM access with byte-lane masks and replicated write data.
- Aligns and sign/zero-extends read data, then returns one response per request under rsp_valid/rsp_ready.

Parameters:
- MEM_ADDRESS_BITS, 16, byte-address width of the attached RAM; legal addresses are below 2**MEM_ADDRESS_BITS.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_address  in  32  byte address
- req_write_data  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_read_data  out  32  extended load data; 0 for stores and errors
- rsp_error  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal size
- mem_address  out  32  word-aligned: {addr[31:2], 2'b00}
- mem_write_enable  out  1  RAM write strobe
- mem_write_mask  out  4  byte lanes to write
- mem_write_data  out  32  lane-replicated store data
- mem_read_enable  out  1  RAM read strobe
- mem_read_mask  out  4  byte lanes to read
- mem_read_data  in  32  RAM read buffer; valid the cycle after mem_read_enable

Behaviour:
- Reset values: state IDLE. req_ready=0 during reset. rsp_valid=0, rsp_read_data=0, rsp_error=0. All mem_* outputs 0.
- FSM states: IDLE, ISSUE, RESPOND.
- IDLE:
  - req_ready=1 in this state only.
  - On handshake, latch all request fields and the computed error code, then go to ISSUE.
- ISSUE (exactly one cycle, then RESPOND):
  - If error is 00, drive exactly one strobe: mem_write_enable for stores, mem_read_enable for loads.
  - Drive the matching mask and mem_address alongside the strobe.
  - If error is nonzero, both strobes stay 0 and no RAM access occurs.
- RESPOND:
  - rsp_valid=1; hold all rsp_* stable until rsp_ready; then go to IDLE.
  - No RAM strobes are driven. This keeps the RAM read buffer stable, so rsp_read_data is formed combinationally from mem_read_data.
- Latency: handshake in cycle T → mem strobe in T+1 → rsp_valid in T+2. Back-to-back throughput is one request per 3 cycles.
- Error priority: illegal size > misaligned > out-of-range.
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0.
  - Out-of-range: addr ≥ 2**MEM_ADDRESS_BITS.
- Lane rules, with o=addr[1:0]:
  - Masks: byte 4'b0001<<o, half 4'b0011<<o, word 4'b1111.
  - Write data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Read data:
  - Shift mem_read_data right by 8*o.
  - Use only bits of the addressed lanes; unmasked lanes of the RAM buffer are stale and are ignored.
  - Byte and half are extended per req_unsigned; word is passed through.
- rsp_read_data is 0 for stores and for all error responses.
- Request inputs are ignored outside IDLE. Holding req_valid high while busy has no effect.
- Reset in ISSUE or RESPOND: return to IDLE and drop the pending response. A write already sampled by the RAM stays committed.

Decomposition:
- Package mem_access_pkg holds:
  - size enum (SIZE_BYTE/HALF/WORD/ILLEGAL)
  - error enum (ERR_OK/MISALIGNED/RANGE/SIZE)
  - state enum (IDLE/ISSUE/RESPOND)
  - function lane_mask(size, offset)
- Sub-module mem_access_align is the natural split: purely combinational load-data shift plus sign/zero extension.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load word @0x100 → mask 1111 on both accesses; rsp_read_data=0xDEADBEEF, rsp_error=00, rsp_valid exactly 2 cycles after each handshake.
- Store byte 0x80 @0x103, then signed load byte @0x103 → write mask 1000, write data 0x80808080; load returns 0xFFFFFF80. Unsigned load of the same byte returns 0x00000080.
- Load half @0x101 → rsp_error=01, no mem strobe in any cycle, rsp_read_data=0. Load word @0x10000 with MEM_ADDRESS_BITS=16 → rsp_error=10, no strobe.
- req_size=11 with a misaligned, out-of-range address → rsp_error=11 (priority check).
- Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and data stay stable, req_ready=0 throughout, no RAM strobes. Raise rsp_ready → IDLE the next cycle.
- Assert reset during RESPOND of a store word 0x12345678 @0x200 → rsp_valid=0 the next cycle. A following load @0x200 returns 0x12345678, proving the write committed.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store adapter in front of the word RAM.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_RANGE      = 2'b10,
    ERR_SIZE       = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    RESPOND = 2'b10
  } state_e;

  // Everything captured at the request handshake.
  typedef struct packed {
    logic        write;
    size_e       size;
    logic        is_unsigned;
    logic [31:0] address;
    logic [31:0] write_data;
    err_e        error;
  } req_t;

  // Byte lanes touched by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return 4'b0011 << offset;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Load-data alignment: shift the addressed lanes down and sign/zero-extend.
module mem_access_align
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_read_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Only the low lanes of the shifted word are used, so stale upper lanes never leak.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    shifted   = mem_read_data >> {offset, 3'b000};
    load_data = '0;
    case (size)
      SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_WORD: load_data = shifted;
      default:   load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store request adapter: validates a request, issues one masked word access
// to the RAM, then returns one aligned and extended response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_ADDRESS_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_read_data,
  output logic [1:0]  rsp_error,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [3:0]  mem_write_mask,
  output logic [31:0] mem_write_data,
  output logic        mem_read_enable,
  output logic [3:0]  mem_read_mask,
  input  logic [31:0] mem_read_data
);

  state_e      state, next_state;
  req_t        req_q;
  err_e        req_error;
  logic        out_of_range;
  logic        handshake;
  logic [31:0] load_data;

  assign handshake    = req_valid & req_ready;
  assign out_of_range = {1'b0, req_address} >= (33'd1 << MEM_ADDRESS_BITS);

  // Classify the incoming request: illegal size beats misalignment beats range.
  always_comb begin
    req_error = ERR_OK;
    if (req_size == SIZE_ILLEGAL)
      req_error = ERR_SIZE;
    else if ((req_size == SIZE_HALF && req_address[0]) ||
             (req_size == SIZE_WORD && req_address[1:0] != 2'b00))
      req_error = ERR_MISALIGNED;
    else if (out_of_range)
      req_error = ERR_RANGE;
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Capture the request and its error code at the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q <= '0;
    end else if (handshake) begin
      req_q.write       <= req_write;
      req_q.size        <= size_e'(req_size);
      req_q.is_unsigned <= req_unsigned;
      req_q.address     <= req_address;
      req_q.write_data  <= req_write_data;
      req_q.error       <= req_error;
    end
  end

  // Next-state logic: one cycle in ISSUE, wait in RESPOND for the consumer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = ISSUE;
      ISSUE:   next_state = RESPOND;
      RESPOND: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  mem_access_align u_align (
    .size          (req_q.size),
    .is_unsigned   (req_q.is_unsigned),
    .offset        (req_q.address[1:0]),
    .mem_read_data (mem_read_data),
    .load_data     (load_data)
  );

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    rsp_read_data    = '0;
    rsp_error        = '0;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_write_mask   = '0;
    mem_write_data   = '0;
    mem_read_enable  = 1'b0;
    mem_read_mask    = '0;
    if (!reset) begin
      case (state)
        IDLE: req_ready = 1'b1;
        ISSUE: begin
          if (req_q.error == ERR_OK) begin
            mem_address = {req_q.address[31:2], 2'b00};
            if (req_q.write) begin
              mem_write_enable = 1'b1;
              mem_write_mask   = lane_mask(req_q.size, req_q.address[1:0]);
              case (req_q.size)
                SIZE_BYTE: mem_write_data = {4{req_q.write_data[7:0]}};
                SIZE_HALF: mem_write_data = {2{req_q.write_data[15:0]}};
                default:   mem_write_data = req_q.write_data;
              endcase
            end else begin
              mem_read_enable = 1'b1;
              mem_read_mask   = lane_mask(req_q.size, req_q.address[1:0]);
            end
          end
        end
        RESPOND: begin
          // No strobe here, so the RAM read buffer is stable and load data stays valid.
          rsp_valid = 1'b1;
          rsp_error = req_q.error;
          if (req_q.error == ERR_OK && !req_q.write) rsp_read_data = load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
